// File: rtl/button_conditioner.sv
// Push-button conditioner: 2-flop synchroniser, debounce and press/release/auto-repeat
// events per button, all registered in the clk domain.
//
// state  | meaning
// IDLE   | debounced level is released, waiting for an accepted press
// DOWN   | held, counting towards the first auto-repeat (idle timer if repeat disabled)
// REPEAT | held past the repeat delay, pulsing every REPEAT_RATE cycles
module button_conditioner #(
  parameter int               N_BTN           = 7,
  parameter int               DEBOUNCE_CYCLES = 500000,
  parameter int               REPEAT_DELAY    = 25000000,
  parameter int               REPEAT_RATE     = 10000000,
  parameter logic [N_BTN-1:0] REPEAT_MASK     = 7'b0001111,
  parameter bit               ACTIVE_LOW_IN   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic             any_press
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {IDLE, DOWN, REPEAT} state_t;

  logic [N_BTN-1:0] raw_pol;
  logic [N_BTN-1:0] sync_q1;
  logic [N_BTN-1:0] btn_s;

  // Inversion happens ahead of the synchroniser so reset leaves it at "not pressed".
  assign raw_pol = ACTIVE_LOW_IN ? ~btn_raw : btn_raw;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q1 <= '0;
      btn_s   <= '0;
    end else begin
      sync_q1 <= raw_pol;
      btn_s   <= sync_q1;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    state_t           state;
    logic             level_q;
    logic             press_q;
    logic             release_q;
    logic [DB_W-1:0]  db_cnt;
    logic [RPT_W-1:0] rpt_cnt;
    logic             differ;
    logic             accept;

    assign differ = (btn_s[i] != level_q);
    assign accept = differ && (db_cnt == DB_LAST);

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state     <= IDLE;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        db_cnt    <= '0;
        rpt_cnt   <= '0;
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;

        if (!differ || accept) begin
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
        if (accept) begin
          level_q <= btn_s[i];
        end

        // A release always wins over a repeat pulse due in the same cycle.
        case (state)
          IDLE: begin
            if (accept) begin
              state   <= DOWN;
              press_q <= 1'b1;
              rpt_cnt <= '0;
            end
          end
          DOWN: begin
            if (accept) begin
              state     <= IDLE;
              release_q <= 1'b1;
              rpt_cnt   <= '0;
            end else if (REPEAT_MASK[i]) begin
              if (rpt_cnt == DELAY_LAST) begin
                state   <= REPEAT;
                press_q <= 1'b1;
                rpt_cnt <= '0;
              end else begin
                rpt_cnt <= rpt_cnt + RPT_W'(1);
              end
            end
          end
          REPEAT: begin
            if (accept) begin
              state     <= IDLE;
              release_q <= 1'b1;
              rpt_cnt   <= '0;
            end else if (rpt_cnt == RATE_LAST) begin
              press_q <= 1'b1;
              rpt_cnt <= '0;
            end else begin
              rpt_cnt <= rpt_cnt + RPT_W'(1);
            end
          end
          default: begin
            state   <= IDLE;
            rpt_cnt <= '0;
          end
        endcase
      end
    end

    assign btn_level[i]   = level_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;
  end

  assign any_press = |btn_press;

endmodule
